line_buffer_sequencer: RTL and testbench

LINE_BUFFER_SEQUENCER -- requirements
Module: line_buffer_sequencer

---
 rtl/line_buffer_sequencer_pkg.sv | 35 +++
 rtl/line_buffer_sequencer_threshold_shadow_reg.sv | 31 +++
 rtl/line_buffer_sequencer.sv | 166 ++++++++++++++++
 tb/tb_line_buffer_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_sequencer_pkg.sv
// Shared constants, state encoding and threshold payload for the line buffer sequencer.
// Thresholds travel as one packed struct between the top and its shadow register.
package line_buffer_sequencer_pkg;

  localparam int unsigned LB_NUM_BUFFERS = 4;
  localparam int unsigned LB_LINE_PIXELS = 640;

  localparam int unsigned HINDEX_W       = 10;
  localparam int unsigned WRPTR_W        = 2;
  localparam int unsigned LINE_CNT_W     = 10;
  localparam int unsigned THRESH_W       = 8;
  localparam int unsigned TAPS_MIN_LINES = 3;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_BLANK      = 2'd1,
    ST_ACTIVE     = 2'd2
  } lb_state_e;

  typedef struct packed {
    logic [THRESH_W-1:0] cb_low;
    logic [THRESH_W-1:0] cb_high;
    logic [THRESH_W-1:0] cr_low;
    logic [THRESH_W-1:0] cr_high;
  } thresholds_t;

  // Full-range window: every Cb/Cr value passes until software narrows it.
  localparam thresholds_t THRESH_RESET = '{
    cb_low:  8'h00,
    cb_high: 8'hFF,
    cr_low:  8'h00,
    cr_high: 8'hFF
  };

endpackage

// File: rtl/line_buffer_sequencer_threshold_shadow_reg.sv
// Pending/active threshold pair; software writes land in pending and are
// promoted to active only at a frame boundary so a frame never sees mixed values.
module line_buffer_sequencer_threshold_shadow_reg
  import line_buffer_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        cfg_we,
  input  thresholds_t cfg,
  output thresholds_t active
);

  thresholds_t pending;

  // A write on the frame-start cycle bypasses pending straight into active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= THRESH_RESET;
      active  <= THRESH_RESET;
    end else begin
      if (cfg_we) begin
        pending <= cfg;
      end
      if (frame_start) begin
        active <= cfg_we ? cfg : pending;
      end
    end
  end

endmodule

// File: rtl/line_buffer_sequencer.sv
// Sequences a ring of 1-bit line buffers across a VGA frame: column address,
// one-hot write enables, fill pointer rotation, line counting and threshold shadowing.
module line_buffer_sequencer
  import line_buffer_sequencer_pkg::*;
#(
  parameter int unsigned NUM_BUFFERS = LB_NUM_BUFFERS,
  parameter int unsigned LINE_PIXELS = LB_LINE_PIXELS
) (
  input  logic                   iVgaClk,
  input  logic                   iRst_n,
  input  logic                   iVgaHRequest,
  input  logic                   iFrameStart,
  input  logic                   iCfgWe,
  input  logic [THRESH_W-1:0]    iCbLow,
  input  logic [THRESH_W-1:0]    iCbHigh,
  input  logic [THRESH_W-1:0]    iCrLow,
  input  logic [THRESH_W-1:0]    iCrHigh,
  output logic [HINDEX_W-1:0]    oHIndex,
  output logic [NUM_BUFFERS-1:0] oWrEn,
  output logic [WRPTR_W-1:0]     oWrPtr,
  output logic                   oTapsValid,
  output logic [LINE_CNT_W-1:0]  oLineCount,
  output logic [THRESH_W-1:0]    oCbLow,
  output logic [THRESH_W-1:0]    oCbHigh,
  output logic [THRESH_W-1:0]    oCrLow,
  output logic [THRESH_W-1:0]    oCrHigh,
  output logic                   oOverrun
);

  localparam logic [HINDEX_W-1:0]   HINDEX_LAST  = HINDEX_W'(LINE_PIXELS - 1);
  localparam logic [WRPTR_W-1:0]    WRPTR_LAST   = WRPTR_W'(NUM_BUFFERS - 1);
  localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX = '1;
  localparam logic [LINE_CNT_W-1:0] TAPS_LINES   = LINE_CNT_W'(TAPS_MIN_LINES);

  lb_state_e state;
  lb_state_e state_next;

  logic [HINDEX_W-1:0]    hindex;
  logic [HINDEX_W-1:0]    hindex_next;
  logic [WRPTR_W-1:0]     wrptr;
  logic [WRPTR_W-1:0]     wrptr_next;
  logic [LINE_CNT_W-1:0]  line_cnt;
  logic [LINE_CNT_W-1:0]  line_cnt_next;
  logic                   taps_valid;
  logic                   taps_valid_next;
  logic                   overrun;
  logic                   overrun_next;
  logic                   line_full;
  logic                   line_full_next;
  logic                   active_px_c;
  logic                   line_end_c;
  logic [NUM_BUFFERS-1:0] wr_en_c;

  thresholds_t cfg;
  thresholds_t thresholds;

  // State register.
  always_ff @(posedge iVgaClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= ST_WAIT_FRAME;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; frame start re-arms from any state.
  always_comb begin
    state_next = state;
    if (iFrameStart) begin
      state_next = ST_BLANK;
    end else begin
      case (state)
        ST_WAIT_FRAME: state_next = ST_WAIT_FRAME;
        ST_BLANK:      if (iVgaHRequest) state_next = ST_ACTIVE;
        ST_ACTIVE:     if (!iVgaHRequest) state_next = ST_BLANK;
        default:       state_next = ST_WAIT_FRAME;
      endcase
    end
  end

  // Output and datapath next-value logic.
  always_comb begin
    active_px_c     = (state != ST_WAIT_FRAME) && iVgaHRequest;
    line_end_c      = (state == ST_ACTIVE) && !iVgaHRequest;
    wr_en_c         = '0;
    hindex_next     = '0;
    wrptr_next      = wrptr;
    line_cnt_next   = line_cnt;
    overrun_next    = overrun;
    line_full_next  = 1'b0;

    if (active_px_c) begin
      wr_en_c = NUM_BUFFERS'(1) << wrptr;
    end

    if (iFrameStart) begin
      wrptr_next    = '0;
      line_cnt_next = '0;
      overrun_next  = 1'b0;
    end else begin
      // line_full marks that all LINE_PIXELS columns were already written.
      if (active_px_c) begin
        hindex_next    = (hindex == HINDEX_LAST) ? hindex : hindex + HINDEX_W'(1);
        line_full_next = line_full || (hindex == HINDEX_LAST);
        if (line_full) begin
          overrun_next = 1'b1;
        end
      end
      if (line_end_c) begin
        wrptr_next = (wrptr == WRPTR_LAST) ? '0 : wrptr + WRPTR_W'(1);
        if (line_cnt != LINE_CNT_MAX) begin
          line_cnt_next = line_cnt + LINE_CNT_W'(1);
        end
      end
    end

    taps_valid_next = (line_cnt_next >= TAPS_LINES);
  end

  // Datapath registers.
  always_ff @(posedge iVgaClk or negedge iRst_n) begin
    if (!iRst_n) begin
      hindex     <= '0;
      wrptr      <= '0;
      line_cnt   <= '0;
      taps_valid <= 1'b0;
      overrun    <= 1'b0;
      line_full  <= 1'b0;
    end else begin
      hindex     <= hindex_next;
      wrptr      <= wrptr_next;
      line_cnt   <= line_cnt_next;
      taps_valid <= taps_valid_next;
      overrun    <= overrun_next;
      line_full  <= line_full_next;
    end
  end

  assign cfg = '{
    cb_low:  iCbLow,
    cb_high: iCbHigh,
    cr_low:  iCrLow,
    cr_high: iCrHigh
  };

  line_buffer_sequencer_threshold_shadow_reg u_threshold_shadow_reg (
    .clk         (iVgaClk),
    .rst_n       (iRst_n),
    .frame_start (iFrameStart),
    .cfg_we      (iCfgWe),
    .cfg         (cfg),
    .active      (thresholds)
  );

  assign oHIndex    = hindex;
  assign oWrEn      = wr_en_c;
  assign oWrPtr     = wrptr;
  assign oTapsValid = taps_valid;
  assign oLineCount = line_cnt;
  assign oOverrun   = overrun;
  assign oCbLow     = thresholds.cb_low;
  assign oCbHigh    = thresholds.cb_high;
  assign oCrLow     = thresholds.cr_low;
  assign oCrHigh    = thresholds.cr_high;

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Self-checking bench for line_buffer_sequencer: directed frames plus randomized
// lines, compared every cycle against a counting model of the frame/line rules.
module tb_line_buffer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hreq;
  logic       fstart;
  logic       cfg_we;
  logic [7:0] cb_lo, cb_hi, cr_lo, cr_hi;

  logic [9:0] oHIndex;
  logic [3:0] oWrEn;
  logic [1:0] oWrPtr;
  logic       oTapsValid;
  logic [9:0] oLineCount;
  logic [7:0] oCbLow, oCbHigh, oCrLow, oCrHigh;
  logic       oOverrun;

  always #5 clk = ~clk;

  line_buffer_sequencer dut (
    .iVgaClk      (clk),
    .iRst_n       (rst_n),
    .iVgaHRequest (hreq),
    .iFrameStart  (fstart),
    .iCfgWe       (cfg_we),
    .iCbLow       (cb_lo),
    .iCbHigh      (cb_hi),
    .iCrLow       (cr_lo),
    .iCrHigh      (cr_hi),
    .oHIndex      (oHIndex),
    .oWrEn        (oWrEn),
    .oWrPtr       (oWrPtr),
    .oTapsValid   (oTapsValid),
    .oLineCount   (oLineCount),
    .oCbLow       (oCbLow),
    .oCbHigh      (oCbHigh),
    .oCrLow       (oCrLow),
    .oCrHigh      (oCrHigh),
    .oOverrun     (oOverrun)
  );

  // Model: frame armed flag, active cycles so far in this line, lines ended this frame.
  bit           m_armed;
  bit           m_in_line;
  bit           m_ovr;
  int           m_k;
  int           m_ends;
  byte unsigned m_pend[4];
  byte unsigned m_act[4];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void m_reset();
    m_armed   = 1'b0;
    m_in_line = 1'b0;
    m_ovr     = 1'b0;
    m_k       = 0;
    m_ends    = 0;
    m_pend    = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    m_act     = '{8'h00, 8'hFF, 8'h00, 8'hFF};
  endfunction

  function automatic void m_edge();
    byte unsigned cfg[4];
    cfg = '{cb_lo, cb_hi, cr_lo, cr_hi};
    if (fstart) begin
      m_armed   = 1'b1;
      m_in_line = 1'b0;
      m_k       = 0;
      m_ends    = 0;
      m_ovr     = 1'b0;
      m_act     = cfg_we ? cfg : m_pend;
    end else if (m_armed) begin
      if (hreq) begin
        if (m_k >= 640) m_ovr = 1'b1;
        m_k++;
        m_in_line = 1'b1;
      end else begin
        if (m_in_line) m_ends++;
        m_in_line = 1'b0;
        m_k       = 0;
      end
    end
    if (cfg_we) m_pend = cfg;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    int lc;
    lc = (m_ends > 1023) ? 1023 : m_ends;
    chk("hindex",     int'(oHIndex),    (m_k > 639) ? 639 : m_k);
    chk("wr_en",      int'(oWrEn),      (m_armed && hreq) ? (1 << (m_ends % 4)) : 0);
    chk("wr_ptr",     int'(oWrPtr),     m_ends % 4);
    chk("line_count", int'(oLineCount), lc);
    chk("taps_valid", int'(oTapsValid), int'(lc >= 3));
    chk("overrun",    int'(oOverrun),   int'(m_ovr));
    chk("cb_low",     int'(oCbLow),     int'(m_act[0]));
    chk("cb_high",    int'(oCbHigh),    int'(m_act[1]));
    chk("cr_low",     int'(oCrLow),     int'(m_act[2]));
    chk("cr_high",    int'(oCrHigh),    int'(m_act[3]));
  endtask

  // One clock: drive inputs, check mid-cycle, advance model on the edge.
  task automatic step(input logic h, input logic fs, input logic we);
    hreq   = h;
    fstart = fs;
    cfg_we = we;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic line(input int na, input int nb);
    repeat (na) step(1'b1, 1'b0, 1'b0);
    repeat (nb) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic rstep(input logic h);
    logic fs;
    logic we;
    fs = ($urandom_range(0, 59) == 0);
    we = ($urandom_range(0, 7) == 0);
    cb_lo = 8'($urandom);
    cb_hi = 8'($urandom);
    cr_lo = 8'($urandom);
    cr_hi = 8'($urandom);
    step(h, fs, we);
  endtask

  initial begin
    rst_n  = 1'b0;
    hreq   = 1'b0;
    fstart = 1'b0;
    cfg_we = 1'b0;
    cb_lo  = 8'h00;
    cb_hi  = 8'hFF;
    cr_lo  = 8'h00;
    cr_hi  = 8'hFF;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("rst_cb_high", int'(oCbHigh), 255);
    chk("rst_hindex",  int'(oHIndex), 0);
    rst_n = 1'b1;

    // Idle before any frame: HRequest must not write.
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    chk("wait_frame_wren", int'(oWrEn), 0);

    // Three full lines, then two more to wrap the pointer.
    step(1'b0, 1'b1, 1'b0);
    line(640, 160);
    line(640, 160);
    chk("taps_after_2", int'(oTapsValid), 0);
    chk("ptr_after_2",  int'(oWrPtr), 2);
    line(640, 160);
    chk("taps_after_3", int'(oTapsValid), 1);
    chk("ptr_after_3",  int'(oWrPtr), 3);
    chk("cnt_after_3",  int'(oLineCount), 3);
    line(640, 160);
    chk("ptr_wrap",     int'(oWrPtr), 0);
    line(640, 160);
    chk("ptr_after_5",  int'(oWrPtr), 1);

    // Threshold write mid-frame takes effect only at the next frame start.
    cb_lo = 8'h60;
    step(1'b0, 1'b0, 1'b1);
    line(10, 5);
    chk("cb_low_hold", int'(oCbLow), 8'h00);
    step(1'b0, 1'b1, 1'b0);
    chk("cb_low_frame", int'(oCbLow), 8'h60);

    // Exactly LINE_PIXELS is fine; one more column is an overrun.
    line(640, 10);
    chk("no_ovr_640", int'(oOverrun), 0);
    repeat (700) step(1'b1, 1'b0, 1'b0);
    chk("ovr_hindex", int'(oHIndex), 639);
    chk("ovr_flag",   int'(oOverrun), 1);
    line(0, 20);
    line(100, 10);
    chk("ovr_sticky", int'(oOverrun), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("ovr_cleared", int'(oOverrun), 0);

    // Frame start on the line-end cycle wins over pointer advance.
    line(20, 5);
    line(20, 5);
    repeat (50) step(1'b1, 1'b0, 1'b0);
    chk("ptr_before_fs", int'(oWrPtr), 2);
    step(1'b0, 1'b1, 1'b0);
    chk("fs_line_end_ptr", int'(oWrPtr), 0);
    chk("fs_line_end_cnt", int'(oLineCount), 0);

    // Write coincident with frame start goes straight to active; inverted range accepted.
    cb_hi = 8'h20;
    cr_lo = 8'h11;
    cr_hi = 8'hEE;
    step(1'b0, 1'b1, 1'b1);
    chk("bypass_cb_high", int'(oCbHigh), 8'h20);
    chk("bypass_cb_low",  int'(oCbLow),  8'h60);
    chk("bypass_cr_high", int'(oCrHigh), 8'hEE);

    // Reset in the middle of a line.
    step(1'b0, 1'b1, 1'b0);
    repeat (300) step(1'b1, 1'b0, 1'b0);
    chk("pre_rst_hindex", int'(oHIndex), 300);
    rst_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    chk("rst_mid_hindex", int'(oHIndex), 0);
    chk("rst_mid_cb_low", int'(oCbLow), 0);
    #1;
    rst_n = 1'b1;
    repeat (5) step(1'b1, 1'b0, 1'b0);
    chk("post_rst_wren", int'(oWrEn), 0);

    // Many short lines to reach line-count saturation.
    step(1'b0, 1'b1, 1'b0);
    repeat (1100) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("cnt_saturate", int'(oLineCount), 1023);

    // Randomized lines, occasional long ones, random frame starts and config writes.
    for (int n = 0; n < 400; n++) begin
      int len;
      int blank;
      len   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(630, 660)) : int'($urandom_range(1, 40));
      blank = int'($urandom_range(1, 8));
      repeat (len) rstep(1'b1);
      repeat (blank) rstep(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
